// File: rtl/cdc_2phase_src_clearable.sv
// ---------------------------------------------------------------------------
// cdc_2phase_src_clearable
//
// Source (transmit) end of a clearable two-phase request/acknowledge
// clock-domain crossing. A word accepted on the valid/ready interface is
// registered onto async_data_o and announced by toggling async_req_o. The
// next word is accepted only after the destination's acknowledge toggle has
// been synchronized back and matches the request phase. A clear abandons any
// in-flight transfer and parks the request line at 0. Both ends then restart
// from a common phase.
//
// Ports
//   clk_i         source-domain clock
//   rst_i         synchronous active-high reset
//   clear_i       synchronous clear; abandons the transfer, forces request to 0
//   data_i        word to send
//   valid_i       data_i is valid
//   ready_o       word is accepted this cycle when valid_i is high
//   async_req_o   registered two-phase request toggle
//   async_ack_i   asynchronous two-phase acknowledge from the destination
//   async_data_o  registered data, stable while a request is outstanding
//   busy_o        a transfer or a clear is in progress
//   drop_o        one-cycle pulse when a clear abandons an in-flight transfer
// ---------------------------------------------------------------------------
module cdc_2phase_src_clearable #(
  parameter int unsigned DATA_WIDTH  = 34,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  async_req_o,
  input  logic                  async_ack_i,
  output logic [DATA_WIDTH-1:0] async_data_o,
  output logic                  busy_o,
  output logic                  drop_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  state_e                  state_r;
  state_e                  state_n_s;
  logic                    req_r;
  logic                    req_n_s;
  logic [DATA_WIDTH-1:0]   data_r;
  logic [DATA_WIDTH-1:0]   data_n_s;
  logic                    drop_r;
  logic                    drop_n_s;
  logic [SYNC_STAGES-1:0]  ack_sync_r;
  logic                    ack_sync_s;
  logic                    ready_s;
  logic                    handshake_s;

  // Acknowledge synchronizer: bit 0 samples the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_sync_r <= '0;
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], async_ack_i};
    end
  end

  assign ack_sync_s  = ack_sync_r[SYNC_STAGES-1];

  // Ready is suppressed during reset and clear so a clear always wins
  // over a simultaneous valid.
  assign ready_s     = (state_r == ST_IDLE) && !clear_i && !rst_i;
  assign handshake_s = valid_i && ready_s;

  // Next-state, request phase, data capture and drop pulse.
  always_comb begin
    state_n_s = state_r;
    req_n_s   = req_r;
    data_n_s  = data_r;
    drop_n_s  = 1'b0;
    if (clear_i) begin
      state_n_s = ST_CLEAR;
      req_n_s   = 1'b0;
      drop_n_s  = (state_r == ST_BUSY);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            state_n_s = ST_BUSY;
            req_n_s   = ~req_r;
            data_n_s  = data_i;
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Acknowledge has caught up with our phase: transfer complete.
          if (ack_sync_s == req_r) begin
            state_n_s = ST_IDLE;
          end else begin
            state_n_s = ST_BUSY;
          end
        end
        ST_CLEAR: begin
          // Leave only once the destination has also returned to phase 0.
          req_n_s = 1'b0;
          if (ack_sync_s == 1'b0) begin
            state_n_s = ST_IDLE;
          end else begin
            state_n_s = ST_CLEAR;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
          req_n_s   = 1'b0;
        end
      endcase
    end
  end

  // State, request, data and drop registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      data_r  <= '0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      req_r   <= req_n_s;
      data_r  <= data_n_s;
      drop_r  <= drop_n_s;
    end
  end

  assign ready_o      = ready_s;
  assign async_req_o  = req_r;
  assign async_data_o = data_r;
  assign busy_o       = (state_r != ST_IDLE);
  assign drop_o       = drop_r;

endmodule

// File: tb/tb_cdc_2phase_src_clearable.sv
// Self-checking bench for cdc_2phase_src_clearable: a transaction-level model
// (mode: idle / waiting / clearing, request phase, held word) is compared
// against the DUT every cycle, plus literal checks for the key scenarios.
module tb_cdc_2phase_src_clearable;
  localparam int DW   = 34;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          clear_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic          async_req_o;
  logic          async_ack_i = 1'b0;
  logic [DW-1:0] async_data_o;
  logic          busy_o;
  logic          drop_o;

  cdc_2phase_src_clearable #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .async_req_o(async_req_o),
    .async_ack_i(async_ack_i), .async_data_o(async_data_o),
    .busy_o(busy_o), .drop_o(drop_o));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode 0 = idle, 1 = waiting for acknowledge, 2 = clearing
  int            m_mode = 0;
  logic          m_phase = 1'b0;
  logic [DW-1:0] m_word = '0;
  logic          m_drop = 1'b0;
  logic [SYNC-1:0] m_hist = '0;   // last SYNC samples of the ack, newest at [0]
  logic          m_acks;

  always @(posedge clk) begin
    m_acks = m_hist[SYNC-1];     // acknowledge as seen SYNC edges ago
    if (rst_i) begin
      m_mode = 0; m_phase = 1'b0; m_word = '0; m_drop = 1'b0; m_hist = '0;
    end else begin
      m_drop = 1'b0;
      if (clear_i) begin
        m_drop  = (m_mode == 1);
        m_mode  = 2;
        m_phase = 1'b0;
      end else if (m_mode == 0 && valid_i) begin
        m_word  = data_i;
        m_phase = ~m_phase;
        m_mode  = 1;
      end else if (m_mode == 1 && m_acks == m_phase) begin
        m_mode = 0;
      end else if (m_mode == 2 && m_acks == 1'b0) begin
        m_mode = 0;
      end
      m_hist = {m_hist[SYNC-2:0], async_ack_i};
    end
  end

  bit cmp_en = 1'b0;
  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    #3;
    if (cmp_en) begin
      chk("ready", ready_o, (m_mode == 0) && !clear_i && !rst_i);
      chk("req",   async_req_o, m_phase);
      chk("data",  async_data_o, m_word);
      chk("busy",  busy_o, m_mode != 0);
      chk("drop",  drop_o, m_drop);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit       lb_en = 1'b0;
  logic [3:0] lb = '0;
  bit       trk_en = 1'b0;
  logic     prev_req = 1'b0;
  int       n_tog = 0;
  logic [DW-1:0] words[$];

  task automatic cyc();
    @(negedge clk);
    if (lb_en) begin
      async_ack_i = lb[3];
      lb = {lb[2:0], async_req_o};
    end
    #1;
    if (trk_en && async_req_o !== prev_req) begin
      n_tog++;
      words.push_back(async_data_o);
      prev_req = async_req_o;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0; lb = '0;
    if (!lb_en) async_ack_i = 1'b0;
    cyc(); cyc();
    cmp_en = 1'b1;
    #1;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_req", async_req_o, 1'b0);
    chk("rst_data", async_data_o, '0);
    rst_i = 1'b0;
    #1;
    chk("rel_ready", ready_o, 1'b1);
  endtask

  task automatic wait_ready(input int max);
    int k;
    k = 0;
    while (!ready_o && k < max) begin
      cyc(); k++;
    end
    chk("wait_ready_timeout", ready_o, 1'b1);
  endtask

  logic [63:0] r64;
  int t_ack, t_rdy, cnt, idx;

  initial begin
    // ---- test 1: reset, single word with loopback ack ----
    cyc();
    lb_en = 1'b1;
    do_reset();
    cyc();
    data_i = 34'h2_DEAD_BEEF; valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    #1;
    chk("t1_data", async_data_o, 34'h2_DEAD_BEEF);
    chk("t1_req", async_req_o, 1'b1);
    t_ack = -1; t_rdy = -1; cnt = 0;
    while (t_rdy < 0 && cnt < 30) begin
      cyc(); cnt++;
      if (t_ack < 0 && async_ack_i) t_ack = cnt;
      #1;
      if (ready_o) t_rdy = cnt;
      else if (t_ack < 0) chk("t1_ready_early", ready_o, 1'b0);
    end
    chk("t1_ack_to_ready", t_rdy - t_ack, 3);

    // ---- test 2: 8 words 0..7, valid held high, loopback ----
    do_reset();
    prev_req = async_req_o; n_tog = 0; words.delete(); trk_en = 1'b1;
    idx = 0; cnt = 0;
    while (idx < 8 && cnt < 300) begin
      data_i = DW'(idx); valid_i = 1'b1;
      #1;
      if (ready_o) idx++;
      cyc(); cnt++;
    end
    valid_i = 1'b0;
    chk("t2_budget", idx, 8);
    wait_ready(30);
    trk_en = 1'b0;
    chk("t2_toggles", n_tog, 8);
    chk("t2_final_req", async_req_o, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t2_word", (i < words.size()) ? 64'(words[i]) : 64'hFFFF, 64'(i));
    end

    // ---- random phase against the model ----
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc();
      rst_i   = ($urandom_range(0, 63) == 0);
      clear_i = ($urandom_range(0, 15) == 0);
      valid_i = $urandom_range(0, 1);
      r64 = {$urandom(), $urandom()};
      data_i = r64[DW-1:0];
    end

    // ---- test 3: clear for one cycle while BUSY, ack withheld ----
    lb_en = 1'b0;
    do_reset();
    cyc();
    data_i = 34'h1_2345_6789; valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    cyc(); cyc(); cyc();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    #1;
    chk("t3_drop", drop_o, 1'b1);
    chk("t3_req", async_req_o, 1'b0);
    chk("t3_data", async_data_o, 34'h1_2345_6789);
    chk("t3_ready_clear", ready_o, 1'b0);
    cyc();
    #1;
    chk("t3_drop_once", drop_o, 1'b0);
    chk("t3_ready", ready_o, 1'b1);

    // ---- test 4: clear held with ack=1, ack drops after 10 cycles ----
    do_reset();
    cyc();
    async_ack_i = 1'b1; clear_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      #1;
      chk("t4_ready_held", ready_o, 1'b0);
      chk("t4_no_drop", drop_o, 1'b0);
    end
    async_ack_i = 1'b0; clear_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1;
      chk("t4_ready_exit", ready_o, i == 3);
    end

    // ---- test 5: simultaneous clear and valid in IDLE ----
    cyc();
    clear_i = 1'b1; valid_i = 1'b1; data_i = 34'h3_5555_AAAA;
    cyc();
    clear_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("t5_req", async_req_o, 1'b0);
    chk("t5_data", async_data_o, '0);
    chk("t5_drop", drop_o, 1'b0);

    // ---- test 6: reset mid-BUSY, then a normal transfer ----
    cyc(); cyc();
    data_i = 34'h0_CAFE_F00D; valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    cyc();
    rst_i = 1'b1;
    cyc();
    #1;
    chk("t6_req", async_req_o, 1'b0);
    chk("t6_data", async_data_o, '0);
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_drop", drop_o, 1'b0);
    chk("t6_ready_rst", ready_o, 1'b0);
    rst_i = 1'b0;
    cyc();
    #1;
    chk("t6_ready", ready_o, 1'b1);
    data_i = 34'h2_0000_0001; valid_i = 1'b1;
    cyc();
    valid_i = 1'b0;
    async_ack_i = 1'b1;
    #1;
    chk("t6_req2", async_req_o, 1'b1);
    chk("t6_busy2", busy_o, 1'b1);
    cyc();
    wait_ready(10);
    chk("t6_data2", async_data_o, 34'h2_0000_0001);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
